// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: byte-stream link around the command decoder.
//   rx_data/rx_valid : host bytes from uart_rx (one-cycle strobe per byte)
//   pt_data/pt_valid : pass-through bytes toward the target uart_tx
//   pt_rdy           : sink accepts; transfer when pt_valid && pt_rdy
// master = host/sink side, slave = decoder side.
interface cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pt_data;
  logic       pt_valid;
  logic       pt_rdy;

  modport master (output rx_data, rx_valid, pt_rdy, input pt_data, pt_valid);
  modport slave  (input rx_data, rx_valid, pt_rdy, output pt_data, pt_valid);
endinterface

// File: rtl/cmd_decoder.sv
// cmd_decoder: byte-level host command parser for the glitcher.
//   0x00 escapes a command; any other first byte N is a payload length and
//   the next N bytes go to the target through a small FIFO.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   bus (slave)     : rx byte stream in, pass-through stream out
//   width_o..       : width, pulse_count, delay config registers
//   glitch_arm, sys_rst, err : one-cycle strobes
//   overflow        : sticky, a pass-through byte was dropped
// Optional feature: define CMD_DECODER_TIMEOUT_EN to abort a partially
// received command/payload after TIMEOUT_CYCLES clocks without a byte.
module cmd_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        rst,
  cmd_decoder_if.slave bus,
  output logic [7:0]  width,
  output logic [7:0]  pulse_count,
  output logic [31:0] delay,
  output logic        glitch_arm,
  output logic        sys_rst,
  output logic        err,
  output logic        overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CMD, ARG, PASS} state_e;

  state_e         state_q;
  logic [7:0]     remain_q, idx_q;
  logic [7:0]     width_q, pcnt_q;
  logic [31:0]    delay_q;
  logic           arm_q, sysrst_q, err_q, ovf_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ptv_q;
  logic           pop, push_req, push, full, tmo_hit;

  assign pop      = ptv_q & bus.pt_rdy;
  assign push_req = bus.rx_valid && (state_q == PASS);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  // A full FIFO still takes the byte if the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

`ifdef CMD_DECODER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  // Counts idle clocks since the last byte while a command/payload is open.
  assign tmo_hit = (state_q != IDLE) && !bus.rx_valid &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst || bus.rx_valid || state_q == IDLE) tmo_q <= '0;
    else                                         tmo_q <= tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Storage only; occupancy and pointers live in the control block.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      idx_q    <= '0;
      width_q  <= '0;
      pcnt_q   <= '0;
      delay_q  <= '0;
      arm_q    <= 1'b0;
      sysrst_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ptv_q    <= 1'b0;
    end else begin
      arm_q    <= 1'b0;
      sysrst_q <= 1'b0;
      err_q    <= 1'b0;

      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ptv_q <= (cnt_d != '0);
      if (push_req && !push) ovf_q <= 1'b1;

      if (tmo_hit) begin
        err_q    <= 1'b1;
        state_q  <= IDLE;
        remain_q <= '0;
      end else if (bus.rx_valid) begin
        unique case (state_q)
          IDLE: begin
            if (bus.rx_data == 8'h00) state_q <= CMD;
            else begin
              remain_q <= bus.rx_data;
              state_q  <= PASS;
            end
          end
          CMD: begin
            state_q <= IDLE;
            case (bus.rx_data)
              8'hFF: begin
                // Soft system reset: later assignments override the FIFO
                // bookkeeping above, so the flush wins over a same-cycle pop.
                sysrst_q <= 1'b1;
                width_q  <= '0;
                pcnt_q   <= '0;
                delay_q  <= '0;
                wr_q     <= '0;
                rd_q     <= '0;
                cnt_q    <= '0;
                ptv_q    <= 1'b0;
                ovf_q    <= 1'b0;
              end
              8'hFE: arm_q <= 1'b1;
              8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23: begin
                idx_q   <= bus.rx_data;
                state_q <= ARG;
              end
              default: err_q <= 1'b1;
            endcase
          end
          ARG: begin
            state_q <= IDLE;
            case (idx_q)
              8'h10:   width_q        <= bus.rx_data;
              8'h11:   pcnt_q         <= bus.rx_data;
              8'h20:   delay_q[7:0]   <= bus.rx_data;
              8'h21:   delay_q[15:8]  <= bus.rx_data;
              8'h22:   delay_q[23:16] <= bus.rx_data;
              8'h23:   delay_q[31:24] <= bus.rx_data;
              default: ;
            endcase
          end
          PASS: begin
            remain_q <= remain_q - 8'd1;
            if (remain_q == 8'd1) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign width        = width_q;
  assign pulse_count  = pcnt_q;
  assign delay        = delay_q;
  assign glitch_arm   = arm_q;
  assign sys_rst      = sysrst_q;
  assign err          = err_q;
  assign overflow     = ovf_q;
  assign bus.pt_valid = ptv_q;
  assign bus.pt_data  = mem_q[rd_q];
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: message-level reference model. The bench builds whole
// messages (writes, arms, resets, bad commands, payloads), tags every byte
// with its effect, and tracks registers plus a FIFO queue cycle by cycle.
module tb_cmd_decoder;
  localparam int DEPTH = 8;
  localparam int TMO   = 50;
  localparam int A_NONE = 0, A_PAY = 1, A_SYS = 2, A_ARM = 3, A_ERR = 4,
                 A_WID = 5, A_CNT = 6, A_DLY = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  width, pulse_count;
  logic [31:0] delay;
  logic        glitch_arm, sys_rst, err, overflow;

  cmd_decoder_if bus();

  cmd_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .width(width), .pulse_count(pulse_count), .delay(delay),
    .glitch_arm(glitch_arm), .sys_rst(sys_rst), .err(err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  logic [7:0]  m_width, m_cnt;
  logic [31:0] m_delay;
  logic        m_arm, m_sys, m_err, m_ovf;
  logic [7:0]  m_q[$];
  logic [7:0]  pl[$];
  bit          mid_msg;
  int          idle_cyc, rdy_mode, max_gap;
  logic [7:0]  idx_tab[6] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("width", width, m_width);
    chk("pulse_count", pulse_count, m_cnt);
    chk("delay", delay, m_delay);
    chk("glitch_arm", glitch_arm, m_arm);
    chk("sys_rst", sys_rst, m_sys);
    chk("err", err, m_err);
    chk("overflow", overflow, m_ovf);
    chk("pt_valid", bus.pt_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("pt_data", bus.pt_data, m_q[0]);
  endtask

  task automatic model_clear();
    m_width = 0; m_cnt = 0; m_delay = 0;
    m_arm = 0; m_sys = 0; m_err = 0; m_ovf = 0;
    m_q.delete(); mid_msg = 0; idle_cyc = 0;
  endtask

  // One clock: check at the falling edge, drive inputs, predict the next edge.
  task automatic tick(input bit v, input logic [7:0] b, input int act, input bit last);
    bit pop;
    check_all();
    bus.rx_valid = v;
    bus.rx_data  = v ? b : 8'h00;
    case (rdy_mode)
      0:       bus.pt_rdy = 1'b0;
      1:       bus.pt_rdy = 1'b1;
      default: bus.pt_rdy = 1'($urandom_range(0, 1));
    endcase
    pop = (m_q.size() != 0) && bus.pt_rdy;
    m_arm = 0; m_sys = 0; m_err = 0;
    if (pop) void'(m_q.pop_front());
    if (v) begin
      idle_cyc = 0;
      mid_msg  = !last;
      if (act == A_PAY) begin
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovf = 1;
      end else if (act == A_SYS) begin
        m_sys = 1; m_width = 0; m_cnt = 0; m_delay = 0; m_q.delete(); m_ovf = 0;
      end else if (act == A_ARM) m_arm = 1;
      else if (act == A_ERR) m_err = 1;
      else if (act == A_WID) m_width = b;
      else if (act == A_CNT) m_cnt = b;
      else if (act >= A_DLY) m_delay[8*(act-A_DLY) +: 8] = b;
    end
`ifdef CMD_DECODER_TIMEOUT_EN
    else if (mid_msg) begin
      idle_cyc++;
      if (idle_cyc == TMO) begin m_err = 1; mid_msg = 0; end
    end
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int act, input bit last);
    repeat ($urandom_range(0, max_gap)) tick(0, 8'h00, A_NONE, 0);
    tick(1, b, act, last);
  endtask

  task automatic send_wr(input logic [7:0] idx, input logic [7:0] val);
    int act;
    act = (idx == 8'h10) ? A_WID : (idx == 8'h11) ? A_CNT : A_DLY + int'(idx - 8'h20);
    send_byte(8'h00, A_NONE, 0);
    send_byte(idx, A_NONE, 0);
    send_byte(val, act, 1);
  endtask

  task automatic send_cmd(input logic [7:0] c, input int act);
    send_byte(8'h00, A_NONE, 0);
    send_byte(c, act, 1);
  endtask

  // Sends the queued payload pl as one length-prefixed message.
  task automatic send_pay();
    send_byte(8'(pl.size()), A_NONE, 0);
    for (int i = 0; i < pl.size(); i++) send_byte(pl[i], A_PAY, i == pl.size() - 1);
  endtask

  task automatic rand_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++)
      pl.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.pt_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic send_bad();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'hFF || b == 8'hFE || b == 8'h10 || b == 8'h11 ||
           (b >= 8'h20 && b <= 8'h23));
    send_cmd(b, A_ERR);
  endtask

  initial begin
    rdy_mode = 1; max_gap = 0;
    do_reset();
    tick(0, 8'h00, A_NONE, 0);

    send_wr(8'h10, 8'h22); send_wr(8'h11, 8'h00); send_wr(8'h20, 8'h32);
    repeat (2) tick(0, 8'h00, A_NONE, 0);

    pl = '{8'hFF, 8'h55, 8'h00, 8'hAA, 8'h00};
    send_pay();
    send_cmd(8'hFE, A_ARM);
    repeat (4) tick(0, 8'h00, A_NONE, 0);

    send_wr(8'h11, 8'h7C); send_wr(8'h23, 8'hA5); send_wr(8'h21, 8'h3C);
    rdy_mode = 0; rand_pl(3); send_pay();
    send_cmd(8'hFF, A_SYS);
    tick(0, 8'h00, A_NONE, 0);

    rdy_mode = 0; rand_pl(12); send_pay();
    send_cmd(8'h42, A_ERR);
    rdy_mode = 1;
    repeat (12) tick(0, 8'h00, A_NONE, 0);

    // Reset mid-payload: FIFO contents are lost and parsing restarts clean.
    rdy_mode = 0;
    send_byte(8'd6, A_NONE, 0);
    for (int i = 0; i < 3; i++) send_byte(8'(i + 1), A_PAY, 0);
    do_reset();
    rdy_mode = 1;
    send_cmd(8'h42, A_ERR);

`ifdef CMD_DECODER_TIMEOUT_EN
    send_byte(8'h00, A_NONE, 0);
    send_byte(8'h10, A_NONE, 0);
    repeat (TMO + 2) tick(0, 8'h00, A_NONE, 0);
    rand_pl(8'h33); send_pay();
`endif

    for (int m = 0; m < 300; m++) begin
      int kind;
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      max_gap  = $urandom_range(0, 2);
      kind     = $urandom_range(0, 9);
      if (kind <= 2)      send_wr(idx_tab[$urandom_range(0, 5)], 8'($urandom));
      else if (kind == 3) send_cmd(8'hFE, A_ARM);
      else if (kind == 4) send_cmd(8'hFF, A_SYS);
      else if (kind == 5) send_bad();
      else begin rand_pl($urandom_range(1, 12)); send_pay(); end
    end
    rdy_mode = 1;
    repeat (20) tick(0, 8'h00, A_NONE, 0);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_decoder.md
# cmd_decoder

Byte-level command parser for the glitcher's host link. It sits between `uart_rx` (host FTDI side) and the glitch engine / target-side `uart_tx`. It decodes escape-prefixed configuration commands into registers and strobes, and forwards length-prefixed payloads to the target through a small FIFO. Everything is synchronous to the single system clock.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: pass-through FIFO entries; power of two, 2..64.
- `TIMEOUT_CYCLES`, 120000: inter-byte timeout in clocks (10 ms at 12 MHz). Used only with `CMD_DECODER_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock (12 MHz).
- `rst` in 1: synchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `width` out 8: glitch pulse width register.
- `pulse_count` out 8: glitch pulse count register.
- `delay` out 32: glitch delay. Byte k is written by command 0x20+k.
- `glitch_arm` out 1: one-cycle strobe on command 0xFE.
- `sys_rst` out 1: one-cycle strobe on command 0xFF.
- `pt_data` out 8: pass-through byte to the target `uart_tx`.
- `pt_valid` out 1: `pt_data` is valid.
- `pt_rdy` in 1: the sink accepts. A transfer happens when `pt_valid && pt_rdy`.
- `err` out 1: one-cycle strobe on an unknown command or a timeout.
- `overflow` out 1: sticky flag, set when a pass-through byte is dropped.

## Operation
- Reset (`rst`=0 on a clock edge):
  - State goes to IDLE.
  - `width`, `pulse_count` and `delay` all go to 0.
  - The FIFO is flushed.
  - All strobes, `pt_valid` and `overflow` go to 0.
- States are IDLE, CMD, ARG and PASS. A state only advances on `rx_valid`, except on timeout.
- IDLE:
  - Byte 0x00 → CMD.
  - Byte N≠0 → load `remain`=N, go to PASS.
- CMD:
  - 0xFF → pulse `sys_rst`. In the same edge, reset all config registers to 0, flush the FIFO and clear `overflow`. → IDLE.
  - 0xFE → pulse `glitch_arm`. → IDLE.
  - 0x10, 0x11, 0x20..0x23 → latch the target index. → ARG.
  - Any other byte → pulse `err`. → IDLE. Registers are unchanged.
- ARG: write the byte to the indexed register (0x10 `width`, 0x11 `pulse_count`, 0x20+k `delay[8k+7:8k]`). → IDLE.
- PASS:
  - Each byte is pushed to the FIFO and `remain` decrements.
  - When `remain` reaches 0 after a byte → IDLE.
  - 0x00 inside the payload is data, not an escape.
- FIFO full on a push:
  - The byte is dropped, `overflow` is set, and `remain` still decrements.
  - If a pop happens in the same cycle, the push is accepted.
- FIFO output:
  - `pt_valid` is high whenever the FIFO is non-empty.
  - `pt_data` holds the head entry and stays stable until it is accepted.
  - Order is preserved.
- `overflow` clears only on reset or on command 0xFF.

## Timing
- All outputs are registered.
- A register write or strobe appears on the edge after the `rx_valid` cycle: the value is visible 1 cycle later and the strobe is high for exactly 1 cycle.
- Pass-through latency: a byte pushed into an empty FIFO has `pt_valid`=1 on the next cycle.
- Throughput is 1 push and 1 pop per cycle.
- `rx_valid` on consecutive cycles is legal; every byte is processed.
- If `rst` is asserted mid-command or mid-payload, the parser drops to IDLE and partial payload bytes in the FIFO are lost.
- `delay` byte writes are independent. There is no atomic 32-bit update; the glitch engine samples `delay` only on `glitch_arm`.

## Configuration
- `CMD_DECODER_TIMEOUT_EN` defined:
  - A counter reloads on every `rx_valid`.
  - In CMD, ARG or PASS, if `TIMEOUT_CYCLES` clocks pass with no byte: pulse `err`, go to IDLE, discard `remain`.
  - FIFO contents are kept.
  - The counter is idle in IDLE.
- Not defined: no counter. The parser waits indefinitely for the next byte and `err` fires only on unknown commands.

## Test plan
- Send 0x00,0xFF after registers are nonzero → `sys_rst` high 1 cycle; `width`, `pulse_count` and `delay` read 0; FIFO empty.
- Send 0x00,0x10,0x22; then 0x00,0x11,0x00; then 0x00,0x20,0x32 → `width`=0x22, `pulse_count`=0x00, `delay`=0x00000032. No strobes fire.
- Send 0x05,0xFF,0x55,0x00,0xAA,0x00 with `pt_rdy`=1 → `pt_data` sequence FF,55,00,AA,00. The parser returns to IDLE. The next byte 0x00 is treated as an escape.
- Send 0x00,0xFE → `glitch_arm` high 1 cycle, 1 cycle after the byte.
- Hold `pt_rdy`=0 and send a 12-byte payload with `FIFO_DEPTH`=8 → first 8 bytes retained in order, `overflow`=1, parser back in IDLE after the 12th byte.
- Send 0x00,0x42 → `err` pulses and registers are unchanged. With `CMD_DECODER_TIMEOUT_EN`, send 0x00,0x10 then idle for `TIMEOUT_CYCLES` → `err` pulses; the next 0x33 is a pass-through length (not a width) and `width` stays unchanged.
